// File: rtl/vc_pkg.sv
// Shared types and constants for the voice corruption block.
// State encoding is reused by the counter logic and the sample transform.
package vc_pkg;

    localparam int VC_DW_DEFAULT = 10;
    localparam int VC_CNT_W      = 8;

    typedef enum logic [1:0] {
        VC_PASS   = 2'd0,
        VC_ATTEN  = 2'd1,
        VC_MUTE   = 2'd2,
        VC_INVERT = 2'd3
    } vc_state_t;

    function automatic vc_state_t vc_next_state(input vc_state_t s);
        vc_state_t n;
        n = VC_PASS;
        unique case (s)
            VC_PASS:   n = VC_ATTEN;
            VC_ATTEN:  n = VC_MUTE;
            VC_MUTE:   n = VC_INVERT;
            VC_INVERT: n = VC_PASS;
            default:   n = VC_PASS;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/vc_sample_xform.sv
// Combinational per-state sample transform.
// INVERT saturates so the most negative input cannot wrap back onto itself.
module vc_sample_xform
    import vc_pkg::*;
#(
    parameter int DW = VC_DW_DEFAULT
) (
    input  vc_state_t       state,
    input  logic [DW-1:0]   sample_in,
    output logic [DW-1:0]   sample_out
);

    localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};

    logic [DW-1:0] atten;
    logic [DW-1:0] neg;

    assign atten = $signed(sample_in) >>> 2;
    assign neg   = (sample_in == SMIN) ? SMAX : (~sample_in + 1'b1);

    // Select the transform matching the current corruption state.
    always_comb begin
        sample_out = sample_in;
        unique case (state)
            VC_PASS:   sample_out = sample_in;
            VC_ATTEN:  sample_out = atten;
            VC_MUTE:   sample_out = '0;
            VC_INVERT: sample_out = neg;
            default:   sample_out = sample_in;
        endcase
    end

endmodule

// File: rtl/voice_corrupt_fsm.sv
// Cycles a voice stream through pass/attenuate/mute/invert on tick counts.
// Samples are registered once, transformed by the state seen at sampling.
module voice_corrupt_fsm
    import vc_pkg::*;
#(
    parameter int DW              = VC_DW_DEFAULT,
    parameter int TICKS_PER_STATE = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          tick,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [1:0]    state,
    output logic          state_change
);

    localparam logic [VC_CNT_W-1:0] LAST =
        VC_CNT_W'(TICKS_PER_STATE - 1);

    vc_state_t           state_q;
    vc_state_t           state_d;
    logic [VC_CNT_W-1:0] cnt_q;
    logic [VC_CNT_W-1:0] cnt_d;
    logic                chg_q;
    logic                chg_d;
    logic                ov_q;
    logic [DW-1:0]       od_q;
    logic [DW-1:0]       od_d;
    vc_state_t           xf_state;
    logic [DW-1:0]       xf_out;

    // Disabled corruption passes samples untouched even before state settles.
    assign xf_state = en ? state_q : VC_PASS;

    vc_sample_xform #(
        .DW(DW)
    ) u_xform (
        .state      (xf_state),
        .sample_in  (in_data),
        .sample_out (xf_out)
    );

    // State, tick counter and change pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= VC_PASS;
            cnt_q   <= '0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chg_q   <= chg_d;
        end
    end

    // Next-state: disable forces PASS, last tick advances the cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        chg_d   = 1'b0;
        unique case (1'b1)
            !en: begin
                state_d = VC_PASS;
                cnt_d   = '0;
                chg_d   = (state_q != VC_PASS);
            end
            en && tick && (cnt_q == LAST): begin
                state_d = vc_next_state(state_q);
                cnt_d   = '0;
                chg_d   = 1'b1;
            end
            en && tick && (cnt_q != LAST): begin
                cnt_d = cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    // Output data holds its value between valid samples.
    always_comb begin
        od_d = od_q;
        if (in_valid) begin
            od_d = xf_out;
        end
    end

    // One-cycle sample pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_q <= 1'b0;
            od_q <= '0;
        end else begin
            ov_q <= in_valid;
            od_q <= od_d;
        end
    end

    assign out_valid    = ov_q;
    assign out_data     = od_q;
    assign state        = state_q;
    assign state_change = chg_q;

endmodule

// File: tb/tb_voice_corrupt_fsm.sv
// Directed vector bench for voice_corrupt_fsm.
// Table-driven walk/transform vectors plus hand-written corner sequences.
module tb_voice_corrupt_fsm;

    localparam int DW = 10;
    localparam int TPS = 2;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          tick;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    state;
    logic          state_change;

    int nvec;
    int nfail;

    typedef struct {
        logic en;
        logic tick;
        logic iv;
        int   d;
        logic eov;
        int   eod;
        int   est;
        logic echg;
    } vec_t;

    vec_t tbl[15];

    voice_corrupt_fsm #(
        .DW(DW),
        .TICKS_PER_STATE(TPS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .tick         (tick),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .state        (state),
        .state_change (state_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic t,
                         input logic v, input int d);
        logic [31:0] dv;
        dv       = d;
        en       = e;
        tick     = t;
        in_valid = v;
        in_data  = dv[DW-1:0];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sdata();
        return int'($signed(out_data));
    endfunction

    function automatic int model_xf(input int st, input int d);
        int r;
        r = d;
        case (st)
            1: r = (d - (((d % 4) + 4) % 4)) / 4;
            2: r = 0;
            3: r = (d == -512) ? 511 : -d;
            default: r = d;
        endcase
        return r;
    endfunction

    initial begin
        int mst;
        int mcnt;
        int d;
        int exp;
        int ovn;

        nvec  = 0;
        nfail = 0;

        // walk + transform vectors, TPS=2
        tbl[0]  = '{1'b1, 1'b0, 1'b1, -512, 1'b1, -512, 0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 0,    1'b0, -512, 0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 0,    1'b0, -512, 1, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, -512, 1'b1, -128, 1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, -1,   1'b1, -1,   1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 0,    1'b0, -1,   1, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 0,    1'b0, -1,   2, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, -512, 1'b1, 0,    2, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 0,    1'b0, 0,    2, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 0,    1'b0, 0,    3, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b1, -512, 1'b1, 511,  3, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 5,    1'b1, -5,   3, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 0,    1'b0, -5,   3, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 0,    1'b0, -5,   0, 1'b1};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 100,  1'b1, 100,  0, 1'b0};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 0);
        #3;
        chk("rst_ov", int'(out_valid), 0);
        chk("rst_od", sdata(), 0);
        chk("rst_st", int'(state), 0);
        chk("rst_chg", int'(state_change), 0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].en, tbl[i].tick, tbl[i].iv, tbl[i].d);
            step();
            chk($sformatf("v%0d_ov", i), int'(out_valid), int'(tbl[i].eov));
            chk($sformatf("v%0d_od", i), sdata(), tbl[i].eod);
            chk($sformatf("v%0d_st", i), int'(state), tbl[i].est);
            chk($sformatf("v%0d_chg", i), int'(state_change),
                int'(tbl[i].echg));
        end

        // coincidence: tick advances PASS->ATTEN with a valid sample
        drive(1'b1, 1'b1, 1'b0, 0);
        step();
        drive(1'b1, 1'b1, 1'b1, 100);
        step();
        chk("coin_od0", sdata(), 100);
        chk("coin_st", int'(state), 1);
        chk("coin_chg", int'(state_change), 1);
        drive(1'b1, 1'b0, 1'b1, 100);
        step();
        chk("coin_od1", sdata(), 25);

        // advance to MUTE, then one extra tick so the counter is mid-count
        drive(1'b1, 1'b1, 1'b0, 0);
        step();
        step();
        chk("dis_pre_st", int'(state), 2);
        step();
        chk("dis_mid_st", int'(state), 2);

        // disable: back to PASS with one pulse, ticks ignored, data clean
        drive(1'b0, 1'b1, 1'b1, 77);
        step();
        chk("dis_st", int'(state), 0);
        chk("dis_chg", int'(state_change), 1);
        chk("dis_od", sdata(), 77);
        drive(1'b0, 1'b1, 1'b1, -3);
        step();
        chk("dis_chg2", int'(state_change), 0);
        chk("dis_od2", sdata(), -3);
        step();
        step();
        chk("dis_st2", int'(state), 0);

        // re-enable: counter was cleared, so one tick must not advance
        drive(1'b1, 1'b1, 1'b0, 0);
        step();
        chk("reen_st0", int'(state), 0);
        step();
        chk("reen_st1", int'(state), 1);

        // async reset mid-cycle with a sample in flight
        drive(1'b1, 1'b0, 1'b1, 100);
        step();
        chk("prers_od", sdata(), 25);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_ov", int'(out_valid), 0);
        chk("mrst_od", sdata(), 0);
        chk("mrst_st", int'(state), 0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 0);
        rst_n = 1'b1;
        step();
        chk("rel_ov0", int'(out_valid), 0);
        drive(1'b1, 1'b0, 1'b1, 42);
        step();
        chk("rel_ov1", int'(out_valid), 1);
        chk("rel_od1", sdata(), 42);

        // back-to-back ramp stream with periodic ticks against a model
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        mst  = 0;
        mcnt = 0;
        ovn  = 0;
        for (int i = 0; i < 50; i++) begin
            logic t;
            t = ((i % 3) == 2);
            d = i * 20 - 500;
            if (i == 7) d = -512;
            exp = model_xf(mst, d);
            drive(1'b1, t, 1'b1, d);
            step();
            if (t) begin
                if (mcnt == TPS - 1) begin
                    mcnt = 0;
                    mst  = (mst + 1) % 4;
                end else begin
                    mcnt++;
                end
            end
            if (out_valid) ovn++;
            chk($sformatf("str%0d_od", i), sdata(), exp);
            chk($sformatf("str%0d_st", i), int'(state), mst);
        end
        drive(1'b1, 1'b0, 1'b0, 0);
        step();
        chk("str_ovcnt", ovn, 50);
        chk("str_ovend", int'(out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/voice_corrupt_fsm.md
VOICE_CORRUPT_FSM -- requirements
Module: voice_corrupt_fsm

Interface
REQ-001 Parameter DW, default 10: audio sample width, two's complement.
REQ-002 Parameter TICKS_PER_STATE, default 8: number of tick pulses spent in each corruption state (legal range 1..255).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  corruption enable; same enable that drives the upstream tick counter.
REQ-006 tick  input  1  single-cycle pulse from the upstream period counter.
REQ-007 in_valid  input  1  in_data carries a new sample this cycle.
REQ-008 in_data  input  DW  input sample, signed.
REQ-009 out_valid  output  1  out_data carries a new processed sample this cycle.
REQ-010 out_data  output  DW  processed sample, signed.
REQ-011 state  output  2  current corruption state encoding.
REQ-012 state_change  output  1  one-cycle pulse, asserted in the cycle after any state transition.

Function
REQ-013 States SHALL be PASS=0, ATTEN=1, MUTE=2 and INVERT=3, with the cycle PASS->ATTEN->MUTE->INVERT->PASS.
REQ-014 An 8-bit tick_cnt SHALL increment on each tick while en=1.
REQ-015 On a tick with en=1 and tick_cnt==TICKS_PER_STATE-1, the block SHALL advance state, clear tick_cnt and pulse state_change in the next cycle.
REQ-016 When en=0, the block SHALL force state to PASS and tick_cnt to 0 on the next edge and ignore tick; state_change pulses only if state was not already PASS.
REQ-017 Sample latency SHALL be exactly 1 cycle: out_valid equals in_valid delayed one cycle, with no back-pressure.
REQ-018 out_data SHALL be computed from the state in effect in the cycle in which in_valid is sampled (pre-transition value when tick and in_valid coincide).
REQ-019 PASS: out = in.
REQ-020 ATTEN: out = in arithmetic-shifted right by 2, sign preserved; -1 maps to -1.
REQ-021 MUTE: out = 0.
REQ-022 INVERT: out = -in, saturated; the most negative value -2^(DW-1) maps to 2^(DW-1)-1.
REQ-023 When en=0, samples SHALL pass unmodified, still with 1-cycle latency.
REQ-024 out_data SHALL hold its last value while out_valid=0.
REQ-025 Back-to-back in_valid on every cycle SHALL be supported with no sample dropped.

Reset
REQ-026 Asserting rst_n=0 SHALL immediately set state=PASS, tick_cnt=0, out_valid=0, out_data=0 and state_change=0, independent of clk.
REQ-027 Reset mid-stream SHALL discard any in-flight sample; the first out_valid after release follows the first in_valid sampled after release.
REQ-028 Deassertion of rst_n SHALL be synchronised externally; the block itself holds no reset-release logic.

Structure
REQ-029 Shared package vc_pkg SHALL hold the state typedef (2-bit enum PASS/ATTEN/MUTE/INVERT) and the default DW constant, for reuse by the counter and the top level.
REQ-030 The purely combinational per-state transform SHALL be a sub-module vc_sample_xform (inputs state and sample, output sample); all registers stay in voice_corrupt_fsm.

Verification
REQ-031 Reset test: in_valid=1, in_data=100, rst_n pulsed low mid-cycle -> out_valid=0 and out_data=0 immediately; state=0.
REQ-032 Walk test: en=1, TICKS_PER_STATE=2, 8 ticks -> state goes 0,1,2,3,0 with one state_change pulse per transition.
REQ-033 Transform test: in_data=-512, DW=10, states 0..3 -> out_data = -512, -128, 0, +511; in_data=-1 in ATTEN -> -1.
REQ-034 Coincidence test: tick advances PASS->ATTEN in the same cycle in_valid=1 with in_data=100 -> out_data=100; the next sample of 100 -> 25.
REQ-035 Disable test: en dropped while in MUTE -> state=PASS next cycle, state_change=1 for one cycle, ticks ignored, samples pass unmodified.
REQ-036 Stream test: in_valid=1 for 50 consecutive cycles with a ramp input -> 50 out_valid cycles, each output equal to the expected transform of the corresponding input one cycle earlier.
